// File: rtl/i8088_bus_responder_if.sv
// i8088 bus responder signal bundle: CPU status/address/data side plus
// the request/acknowledge memory/IO port. slave = responder, master = CPU/fabric.
interface i8088_bus_responder_if;
  logic [2:0]  S2_S0;
  logic [19:0] AD;
  logic [7:0]  CPU_DOUT;
  logic        READY;
  logic [7:0]  DIN;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic        MEM_IO;
  logic [19:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic        MEM_ACK;
  logic [7:0]  MEM_RDATA;
  logic [7:0]  INTA_VECTOR;
  logic        INTA_ACK;
  logic        HALTED;
  logic        BUS_TIMEOUT;

  modport slave (
    input  S2_S0, AD, CPU_DOUT,
    input  MEM_ACK, MEM_RDATA, INTA_VECTOR,
    output READY, DIN,
    output MEM_REQ, MEM_WE, MEM_IO,
    output MEM_ADDR, MEM_WDATA,
    output INTA_ACK, HALTED, BUS_TIMEOUT
  );

  modport master (
    output S2_S0, AD, CPU_DOUT,
    output MEM_ACK, MEM_RDATA, INTA_VECTOR,
    input  READY, DIN,
    input  MEM_REQ, MEM_WE, MEM_IO,
    input  MEM_ADDR, MEM_WDATA,
    input  INTA_ACK, HALTED, BUS_TIMEOUT
  );
endinterface

// File: rtl/i8088_bus_responder.sv
// i8088 target-side bus agent: classifies CPU cycles, issues them to a
// req/ack port, stretches READY, returns read data / INTA vector, flags HALT.
// Ports: CLK, RESET (sync, active high), bus (i8088_bus_responder_if.slave).
// Optional watchdog: define I8088_BUS_TIMEOUT_EN (uses TIMEOUT_CYCLES).
module i8088_bus_responder #(
  parameter int unsigned WAIT_MEM       = 0,
  parameter int unsigned WAIT_IO        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        CLK,
  input  logic                        RESET,
  i8088_bus_responder_if.slave        bus
);

  localparam int WW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    REQ,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [2:0]      prev_st;
  logic [2:0]      typ;
  logic [WW-1:0]   wcnt;
  logic            ack_seen;
  logic            inta_pair;

  logic            start;
  logic            st_inta;
  logic            st_halt;
  logic            st_io;
  logic            st_wr;
  logic            typ_inta;
  logic            typ_rd;
  logic            ack_now;
  logic            finish;
  logic            tmo_hit;

  assign start   = (prev_st == 3'b111) &&
                   (bus.S2_S0 != 3'b111);
  assign st_inta = (bus.S2_S0 == 3'b000);
  assign st_halt = (bus.S2_S0 == 3'b011);
  assign st_io   = (bus.S2_S0 == 3'b001) ||
                   (bus.S2_S0 == 3'b010);
  assign st_wr   = (bus.S2_S0 == 3'b010) ||
                   (bus.S2_S0 == 3'b110);
  assign typ_inta = (typ == 3'b000);
  assign typ_rd   = (typ == 3'b001) ||
                    (typ == 3'b100) ||
                    (typ == 3'b101);

  always_comb begin
    state_nx = state;
    ack_now  = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = st_halt ? DONE : ADDR;
      end
      ADDR: state_nx = REQ;
      REQ: begin
        ack_now = bus.MEM_ACK | tmo_hit;
        if ((ack_seen || ack_now) &&
            (wcnt == '0)) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        // a start here means status skipped passive
        if (start || bus.S2_S0 == 3'b111)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_st       <= 3'b111;
      typ           <= 3'b111;
      wcnt          <= '0;
      ack_seen      <= 1'b0;
      inta_pair     <= 1'b0;
      bus.READY     <= 1'b1;
      bus.DIN       <= 8'hFF;
      bus.MEM_REQ   <= 1'b0;
      bus.MEM_WE    <= 1'b0;
      bus.MEM_IO    <= 1'b0;
      bus.MEM_ADDR  <= '0;
      bus.MEM_WDATA <= '0;
      bus.INTA_ACK  <= 1'b0;
      bus.HALTED    <= 1'b0;
    end else begin
      prev_st      <= bus.S2_S0;
      bus.INTA_ACK <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            typ       <= bus.S2_S0;
            inta_pair <= st_inta & ~inta_pair;
            bus.HALTED <= st_halt;
            if (!st_halt) begin
              bus.READY  <= 1'b0;
              ack_seen   <= 1'b0;
              wcnt       <= (st_io || st_inta) ?
                            WW'(WAIT_IO) :
                            WW'(WAIT_MEM);
              bus.MEM_WE <= st_wr;
              bus.MEM_IO <= st_io;
              bus.MEM_ADDR <= st_io ?
                {4'h0, bus.AD[15:0]} :
                bus.AD;
            end
          end
        end
        ADDR: begin
          bus.MEM_WDATA <= bus.CPU_DOUT;
          // INTA has no backing access
          if (typ_inta) ack_seen    <= 1'b1;
          else          bus.MEM_REQ <= 1'b1;
        end
        REQ: begin
          if (wcnt != '0) wcnt <= wcnt - 1'b1;
          if (ack_now) begin
            ack_seen    <= 1'b1;
            bus.MEM_REQ <= 1'b0;
            if (typ_rd)
              bus.DIN <= tmo_hit ? 8'hFF :
                         bus.MEM_RDATA;
          end
          if (finish) begin
            bus.READY <= 1'b1;
            if (typ_inta) begin
              bus.DIN <= inta_pair ? 8'hFF :
                         bus.INTA_VECTOR;
              bus.INTA_ACK <= ~inta_pair;
            end
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

`ifdef I8088_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  assign tmo_hit = (state == REQ) && !ack_seen &&
                   !bus.MEM_ACK &&
                   (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tcnt            <= '0;
      bus.BUS_TIMEOUT <= 1'b0;
    end else begin
      bus.BUS_TIMEOUT <= tmo_hit;
      if (state != REQ)  tcnt <= '0;
      else if (!tmo_hit) tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign tmo_hit         = 1'b0;
  assign bus.BUS_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_i8088_bus_responder.sv
// Bench for i8088_bus_responder: directed plan cases plus randomized
// bus cycles against a cycle-count/value reference model.
module tb_i8088_bus_responder;
  localparam int WM  = 0;
  localparam int WIO = 3;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  i8088_bus_responder_if bus();

  i8088_bus_responder #(
    .WAIT_MEM(WM), .WAIT_IO(WIO), .TIMEOUT_CYCLES(16)
  ) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errs = 0;

  logic [7:0] m_din = 8'hFF;
  bit m_pair = 0;
  bit m_halt = 0;

  int e_low, e_req, e_iack;
  logic [19:0] e_addr;
  logic [7:0] e_din;
  bit e_halt;

  logic [19:0] o_addr;
  logic o_we, o_io, o_halted;
  logic [7:0] o_wd, o_din;
  int o_low, o_req, o_iack, o_bto;
  bit o_to;

  task automatic bus_cycle(input logic [2:0] st, input logic [19:0] a,
                           input logic [7:0] wd, input int d,
                           input logic [7:0] rd);
    bit seen = 0;
    o_low = 0; o_req = 0; o_iack = 0; o_bto = 0; o_to = 1;
    bus.S2_S0 = st; bus.AD = a; bus.CPU_DOUT = wd; bus.MEM_RDATA = rd;
    for (int i = 1; i <= 200; i++) begin
      @(posedge CLK); @(negedge CLK);
      bus.MEM_ACK = (d > 0 && i - 1 == d);
      if (i == 1) bus.AD = 20'($urandom);
      if (i == 2) begin
        o_addr = bus.MEM_ADDR; o_we = bus.MEM_WE; o_io = bus.MEM_IO;
      end
      if (!bus.READY) begin o_low++; seen = 1; end
      if (bus.MEM_REQ) o_req++;
      if (bus.INTA_ACK) o_iack++;
      if (bus.BUS_TIMEOUT) o_bto++;
      if ((bus.READY && seen) || (st == 3'b011 && i == 4)) begin
        o_to = 0;
        break;
      end
    end
    o_din = bus.DIN; o_wd = bus.MEM_WDATA; o_halted = bus.HALTED;
    bus.MEM_ACK = 0; bus.S2_S0 = 3'b111;
    repeat (2) begin
      @(posedge CLK); @(negedge CLK);
      if (bus.INTA_ACK) o_iack++;
      if (bus.BUS_TIMEOUT) o_bto++;
      if (bus.MEM_REQ) o_req++;
    end
  endtask

  // Reference: expected results from the cycle type and ack timing alone.
  task automatic do_cycle(input logic [2:0] st, input logic [19:0] a,
                          input logic [7:0] wd, input int d,
                          input logic [7:0] rd, input logic [7:0] vec);
    bit is_io = (st == 3'd1 || st == 3'd2);
    bit is_rd = (st == 3'd1 || st == 3'd4 || st == 3'd5);
    int w = is_io ? WIO : WM;
    bus.INTA_VECTOR = vec;
    e_iack = 0; e_req = 0; e_low = 0;
    if (st == 3'd3) begin
      m_halt = 1; m_pair = 0;
    end else if (st == 3'd0) begin
      m_halt = 0; m_pair = !m_pair;
      e_low = 2 + WIO;
      if (m_pair) m_din = 8'hFF;
      else begin m_din = vec; e_iack = 1; end
    end else begin
      m_halt = 0; m_pair = 0;
      e_req = d;
      e_low = (d + 1 > w + 2) ? d + 1 : w + 2;
      if (is_rd) m_din = rd;
    end
    e_din = m_din; e_halt = m_halt;
    e_addr = is_io ? {4'h0, a[15:0]} : a;
    bus_cycle(st, a, wd, d, rd);
  endtask

  task automatic test_reset();
    vectors++;
    if ({bus.READY, bus.DIN} !== 9'h1FF) begin
      errs++; $display("FAIL rst_ready_din got %h want 1ff", {bus.READY, bus.DIN});
    end
    vectors++;
    if ({bus.MEM_REQ, bus.MEM_WE, bus.MEM_IO, bus.INTA_ACK, bus.HALTED,
         bus.BUS_TIMEOUT} !== 6'b0) begin
      errs++; $display("FAIL rst_ctrl got %b want 000000",
        {bus.MEM_REQ, bus.MEM_WE, bus.MEM_IO, bus.INTA_ACK, bus.HALTED,
         bus.BUS_TIMEOUT});
    end
    vectors++;
    if ({bus.MEM_ADDR, bus.MEM_WDATA} !== 28'h0) begin
      errs++; $display("FAIL rst_addr_wd got %h want 0", {bus.MEM_ADDR, bus.MEM_WDATA});
    end
  endtask

  task automatic test_mem_read();
    do_cycle(3'b101, 20'h12345, 8'h00, 1, 8'hA5, 8'h00);
    vectors++; if (o_to !== 0) begin errs++; $display("FAIL memrd_stall got %0d want 0", o_to); end
    vectors++; if (o_low !== 2) begin errs++; $display("FAIL memrd_low got %0d want 2", o_low); end
    vectors++; if (o_din !== 8'hA5) begin errs++; $display("FAIL memrd_din got %h want a5", o_din); end
    vectors++; if (o_addr !== 20'h12345) begin errs++; $display("FAIL memrd_addr got %h want 12345", o_addr); end
    vectors++; if ({o_we, o_io} !== 2'b00) begin errs++; $display("FAIL memrd_we_io got %b want 00", {o_we, o_io}); end
  endtask

  task automatic test_io_write();
    do_cycle(3'b010, 20'hA0061, 8'h3C, 1, 8'h77, 8'h00);
    vectors++; if (o_low !== 5) begin errs++; $display("FAIL iowr_low got %0d want 5", o_low); end
    vectors++; if ({o_we, o_io} !== 2'b11) begin errs++; $display("FAIL iowr_we_io got %b want 11", {o_we, o_io}); end
    vectors++; if (o_wd !== 8'h3C) begin errs++; $display("FAIL iowr_wdata got %h want 3c", o_wd); end
    vectors++; if (o_addr !== 20'h00061) begin errs++; $display("FAIL iowr_addr got %h want 00061", o_addr); end
    vectors++; if (o_din !== 8'hA5) begin errs++; $display("FAIL iowr_din_hold got %h want a5", o_din); end
  endtask

  task automatic test_inta();
    int ack_sum, req_sum;
    do_cycle(3'b000, 20'h0, 8'h00, 0, 8'h00, 8'h08);
    ack_sum = o_iack; req_sum = o_req;
    vectors++; if (o_din !== 8'hFF) begin errs++; $display("FAIL inta1_din got %h want ff", o_din); end
    do_cycle(3'b000, 20'h0, 8'h00, 0, 8'h00, 8'h08);
    ack_sum += o_iack; req_sum += o_req;
    vectors++; if (o_din !== 8'h08) begin errs++; $display("FAIL inta2_din got %h want 08", o_din); end
    vectors++; if (o_iack !== 1 || ack_sum !== 1) begin errs++; $display("FAIL inta_ack got %0d want 1", ack_sum); end
    vectors++; if (req_sum !== 0) begin errs++; $display("FAIL inta_req got %0d want 0", req_sum); end
  endtask

  task automatic test_halt();
    do_cycle(3'b011, 20'h0, 8'h00, 0, 8'h00, 8'h00);
    vectors++; if (o_halted !== 1'b1) begin errs++; $display("FAIL halt_set got %b want 1", o_halted); end
    vectors++; if (o_low !== 0 || o_req !== 0) begin errs++; $display("FAIL halt_quiet got low %0d req %0d want 0 0", o_low, o_req); end
    do_cycle(3'b100, 20'hFFFF0, 8'h00, 2, 8'hEA, 8'h00);
    vectors++; if (o_halted !== 1'b0) begin errs++; $display("FAIL halt_clr got %b want 0", o_halted); end
    vectors++; if (o_din !== 8'hEA) begin errs++; $display("FAIL code_din got %h want ea", o_din); end
  endtask

  task automatic test_reset_mid();
    bus.S2_S0 = 3'b101; bus.AD = 20'h04000; bus.MEM_RDATA = 8'h5A;
    repeat (3) begin @(posedge CLK); @(negedge CLK); end
    vectors++; if (bus.MEM_REQ !== 1'b1) begin errs++; $display("FAIL rmid_req_pre got %b want 1", bus.MEM_REQ); end
    RESET = 1; bus.S2_S0 = 3'b111;
    @(posedge CLK); @(negedge CLK);
    RESET = 0;
    vectors++; if ({bus.MEM_REQ, bus.READY, bus.DIN} !== 10'h1FF) begin
      errs++; $display("FAIL rmid_after got %h want 1ff", {bus.MEM_REQ, bus.READY, bus.DIN});
    end
    repeat (2) begin @(posedge CLK); @(negedge CLK); end
    bus.MEM_ACK = 1;
    @(posedge CLK); @(negedge CLK);
    bus.MEM_ACK = 0;
    @(posedge CLK); @(negedge CLK);
    vectors++; if ({bus.MEM_REQ, bus.READY, bus.DIN} !== 10'h1FF) begin
      errs++; $display("FAIL rmid_late_ack got %h want 1ff", {bus.MEM_REQ, bus.READY, bus.DIN});
    end
    m_din = 8'hFF; m_pair = 0; m_halt = 0;
    do_cycle(3'b101, 20'h00123, 8'h00, 1, 8'h42, 8'h00);
    vectors++; if (o_din !== 8'h42 || o_low !== 2) begin
      errs++; $display("FAIL rmid_recover got din %h low %0d want 42 2", o_din, o_low);
    end
  endtask

  task automatic test_random();
    logic [2:0] st;
    bit req_t, wr_t;
    for (int n = 0; n < 40; n++) begin
      st = 3'($urandom_range(0, 6));
      req_t = !(st == 3'd0 || st == 3'd3);
      wr_t = (st == 3'd2 || st == 3'd6);
      do_cycle(st, 20'($urandom), 8'($urandom),
               req_t ? int'($urandom_range(1, 6)) : 0,
               8'($urandom), 8'($urandom));
      vectors++; if (o_to !== 0) begin errs++; $display("FAIL rnd%0d_stall st %0d", n, st); end
      vectors++; if (o_low !== e_low) begin errs++; $display("FAIL rnd%0d_low st %0d got %0d want %0d", n, st, o_low, e_low); end
      vectors++; if (o_din !== e_din) begin errs++; $display("FAIL rnd%0d_din st %0d got %h want %h", n, st, o_din, e_din); end
      vectors++; if (o_req !== e_req) begin errs++; $display("FAIL rnd%0d_req st %0d got %0d want %0d", n, st, o_req, e_req); end
      vectors++; if (o_iack !== e_iack) begin errs++; $display("FAIL rnd%0d_iack got %0d want %0d", n, o_iack, e_iack); end
      vectors++; if (o_halted !== e_halt) begin errs++; $display("FAIL rnd%0d_halt got %b want %b", n, o_halted, e_halt); end
      if (req_t) begin
        vectors++;
        if ({o_addr, o_we, o_io} !== {e_addr, wr_t, st == 3'd1 || st == 3'd2}) begin
          errs++; $display("FAIL rnd%0d_addr st %0d got %h %b%b want %h", n, st, o_addr, o_we, o_io, e_addr);
        end
      end
      if (wr_t) begin
        vectors++; if (o_wd !== bus.CPU_DOUT) begin errs++; $display("FAIL rnd%0d_wdata got %h want %h", n, o_wd, bus.CPU_DOUT); end
      end
    end
  endtask

`ifdef I8088_BUS_TIMEOUT_EN
  task automatic test_timeout();
    bus_cycle(3'b101, 20'h00200, 8'h00, 0, 8'h99);
    vectors++; if (o_bto !== 1) begin errs++; $display("FAIL tmo_pulse got %0d want 1", o_bto); end
    vectors++; if (o_low !== 17) begin errs++; $display("FAIL tmo_low got %0d want 17", o_low); end
    vectors++; if (o_din !== 8'hFF) begin errs++; $display("FAIL tmo_din got %h want ff", o_din); end
    vectors++; if (o_req !== 16) begin errs++; $display("FAIL tmo_req got %0d want 16", o_req); end
  endtask
`endif

  initial begin
    bus.S2_S0 = 3'b111; bus.AD = '0; bus.CPU_DOUT = '0;
    bus.MEM_ACK = 0; bus.MEM_RDATA = '0; bus.INTA_VECTOR = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 0;
    test_reset();
    test_mem_read();
    test_io_write();
    test_inta();
    test_halt();
    test_reset_mid();
    test_random();
`ifdef I8088_BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
